// File: rtl/pipe_mux_pkg.sv
// Sizing helpers for the pipelined mux tree: select width, level count, padded input
// count and the offsets used to pack every level's data/control into flat chains.
package pipe_mux_pkg;

    // Smallest r such that 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        longint v;
        r = 32'sd0;
        v = 64'sd1;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if (v < longint'(n)) begin
                v = v * 64'sd2;
                r = r + 32'sd1;
            end
        end
        return r;
    endfunction

    // Select bits consumed by one RADIX:1 level.
    function automatic int calc_lb(input int radix);
        return clog2(radix);
    endfunction

    // Number of RADIX:1 levels needed to cover n_in inputs.
    function automatic int calc_levels(input int n_in, input int radix);
        int l;
        longint p;
        l = 32'sd0;
        p = 64'sd1;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if (p < longint'(n_in)) begin
                p = p * longint'(radix);
                l = l + 32'sd1;
            end
        end
        return l;
    endfunction

    // Input count after padding the tree to a full RADIX**LEVELS.
    function automatic int pad_count(input int n_in, input int radix);
        int p;
        p = 32'sd1;
        for (int i = 32'sd0; i < calc_levels(n_in, radix); i++) begin
            p = p * radix;
        end
        return p;
    endfunction

    // Bit offset of the data segment feeding level k (segment LEVELS holds y).
    function automatic int data_off(input int k, input int pad_n, input int lb, input int width);
        int off;
        off = 32'sd0;
        for (int j = 32'sd0; j < k; j++) begin
            off = off + (pad_n >> (j * lb)) * width;
        end
        return off;
    endfunction

    // Bit offset of the control segment feeding level k: {flags, unconsumed select bits}.
    function automatic int ctl_off(input int k, input int levels, input int lb, input int fw);
        int off;
        off = 32'sd0;
        for (int j = 32'sd0; j < k; j++) begin
            off = off + fw + (levels - j) * lb;
        end
        return off;
    endfunction

endpackage

// File: rtl/pipe_mux_level.sv
// One tree level: M_OUT groups of RADIX:1 muxes steered by the low LB control bits,
// followed by a stage register for data and the remaining control bits (enable = adv).
module pipe_mux_level #(
    parameter int M_OUT = 8,
    parameter int RADIX = 8,
    parameter int WIDTH = 1,
    parameter int LB    = 3,
    parameter int PW    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        adv,
    input  logic [M_OUT*RADIX*WIDTH-1:0] src_data,
    input  logic [LB+PW-1:0]            src_ctl,
    output logic [M_OUT*WIDTH-1:0]      dst_data,
    output logic [PW-1:0]               dst_ctl
);

    logic [LB-1:0]          sel_s;
    logic [M_OUT*WIDTH-1:0] mux_s;
    logic [M_OUT*WIDTH-1:0] data_r;
    logic [PW-1:0]          ctl_r;

    assign sel_s = src_ctl[LB-1:0];

    // Every group picks the same lane, so one select field serves the whole level.
    always_comb begin
        mux_s = '0;
        for (int g = 32'sd0; g < M_OUT; g++) begin
            mux_s[g*WIDTH +: WIDTH] = src_data[(g*RADIX + int'(sel_s))*WIDTH +: WIDTH];
        end
    end

    // Stage register: data and carried control advance together, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            ctl_r  <= '0;
        end else if (adv) begin
            data_r <= mux_s;
            ctl_r  <= src_ctl[LB+PW-1:LB];
        end
    end

    assign dst_data = data_r;
    assign dst_ctl  = ctl_r;

endmodule

// File: rtl/pipe_mux_tree.sv
// Pipelined N_IN:1 mux tree built from RADIX:1 levels with a global valid/ready stall.
// Optional out-of-range select flag on err when PIPE_MUX_RANGE_CHK_EN is defined.
module pipe_mux_tree
    import pipe_mux_pkg::*;
#(
    parameter int N_IN  = 64,
    parameter int WIDTH = 1,
    parameter int RADIX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN*WIDTH-1:0]    a,
    input  logic [clog2(N_IN)-1:0]   s,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err
);

    localparam int SELW   = clog2(N_IN);
    localparam int LB     = calc_lb(RADIX);
    localparam int LEVELS = calc_levels(N_IN, RADIX);
    localparam int PAD_N  = pad_count(N_IN, RADIX);
    localparam int SPW    = LEVELS * LB;
`ifdef PIPE_MUX_RANGE_CHK_EN
    localparam int FW     = 2;
`else
    localparam int FW     = 1;
`endif
    localparam int DTOT   = data_off(LEVELS + 1, PAD_N, LB, WIDTH);
    localparam int CTOT   = ctl_off(LEVELS + 1, LEVELS, LB, FW);
    localparam int D_LAST = data_off(LEVELS, PAD_N, LB, WIDTH);
    localparam int C_LAST = ctl_off(LEVELS, LEVELS, LB, FW);

    logic [DTOT-1:0] data_chain_s;
    logic [CTOT-1:0] ctl_chain_s;
    logic [SPW-1:0]  sel_pad_s;
    logic [FW-1:0]   flags_s;
    logic            adv_s;

    assign adv_s    = out_ready | ~out_valid;
    assign in_ready = adv_s;

    // Padded lanes above N_IN read as zero, so out-of-range selects yield y = 0.
    assign data_chain_s[PAD_N*WIDTH-1:0] = (PAD_N*WIDTH)'(a);
    assign sel_pad_s = SPW'(s);

    // Flags ride above the select bits; each level strips its LB bits off the bottom.
`ifdef PIPE_MUX_RANGE_CHK_EN
    assign flags_s = {in_valid & (32'(s) >= 32'(N_IN)), in_valid};
`else
    assign flags_s = in_valid;
`endif
    assign ctl_chain_s[FW+SPW-1:0] = {flags_s, sel_pad_s};

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int M_OUT  = PAD_N >> ((k + 1) * LB);
        localparam int PW     = FW + (LEVELS - k - 1) * LB;
        localparam int D_IN   = data_off(k, PAD_N, LB, WIDTH);
        localparam int D_OUT  = data_off(k + 1, PAD_N, LB, WIDTH);
        localparam int C_IN   = ctl_off(k, LEVELS, LB, FW);
        localparam int C_OUT  = ctl_off(k + 1, LEVELS, LB, FW);

        pipe_mux_level #(
            .M_OUT (M_OUT),
            .RADIX (RADIX),
            .WIDTH (WIDTH),
            .LB    (LB),
            .PW    (PW)
        ) u_level (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv_s),
            .src_data (data_chain_s[D_IN +: M_OUT*RADIX*WIDTH]),
            .src_ctl  (ctl_chain_s[C_IN +: LB+PW]),
            .dst_data (data_chain_s[D_OUT +: M_OUT*WIDTH]),
            .dst_ctl  (ctl_chain_s[C_OUT +: PW])
        );
    end

    assign y         = data_chain_s[D_LAST +: WIDTH];
    assign out_valid = ctl_chain_s[C_LAST];
`ifdef PIPE_MUX_RANGE_CHK_EN
    assign err       = ctl_chain_s[C_LAST + 1];
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux_tree.sv
// Self-checking bench for pipe_mux_tree: three configurations (64/1/8, 40/4/8, 5/1/2)
// compared cycle by cycle against a queue-based reference of the stall/latency rules.
module tb_pipe_mux_tree;

`ifdef PIPE_MUX_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int del_a = 0;
    string phase = "reset";

    // A: N_IN=64 WIDTH=1 RADIX=8
    logic [63:0]  a_a;  logic [5:0] s_a;  logic iv_a, ir_a, y_a, ov_a, or_a, err_a;
    // B: N_IN=40 WIDTH=4 RADIX=8
    logic [159:0] a_b;  logic [5:0] s_b;  logic iv_b, ir_b, ov_b, or_b, err_b;
    logic [3:0]   y_b;
    // C: N_IN=5 WIDTH=1 RADIX=2
    logic [4:0]   a_c;  logic [2:0] s_c;  logic iv_c, ir_c, y_c, ov_c, or_c, err_c;

    pipe_mux_tree #(.N_IN(64), .WIDTH(1), .RADIX(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .a(a_a), .s(s_a), .in_valid(iv_a), .in_ready(ir_a),
        .y(y_a), .out_valid(ov_a), .out_ready(or_a), .err(err_a));
    pipe_mux_tree #(.N_IN(40), .WIDTH(4), .RADIX(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .a(a_b), .s(s_b), .in_valid(iv_b), .in_ready(ir_b),
        .y(y_b), .out_valid(ov_b), .out_ready(or_b), .err(err_b));
    pipe_mux_tree #(.N_IN(5), .WIDTH(1), .RADIX(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .a(a_c), .s(s_c), .in_valid(iv_c), .in_ready(ir_c),
        .y(y_c), .out_valid(ov_c), .out_ready(or_c), .err(err_c));

    // Expected pipeline content: element 0 is what the output should show, the last
    // element is the most recently accepted item. Length = number of levels.
    typedef struct {
        logic       v;
        logic [3:0] y;
        logic       e;
    } mdl_t;
    mdl_t qa[$];
    mdl_t qb[$];
    mdl_t qc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        mdl_t z;
        z.v = 1'b0; z.y = 4'h0; z.e = 1'b0;
        qa = {}; qb = {}; qc = {};
        repeat (2) qa.push_back(z);
        repeat (2) qb.push_back(z);
        repeat (3) qc.push_back(z);
    endtask

    task automatic idle_inputs();
        a_a = '0; s_a = '0; iv_a = 1'b0; or_a = 1'b1;
        a_b = '0; s_b = '0; iv_b = 1'b0; or_b = 1'b1;
        a_c = '0; s_c = '0; iv_c = 1'b0; or_c = 1'b1;
    endtask

    // One clock: inputs already driven after the falling edge.
    task automatic cycle();
        mdl_t e;
        bit adv_a, adv_b, adv_c;
        #1;
        adv_a = or_a | ~qa[0].v;
        adv_b = or_b | ~qb[0].v;
        adv_c = or_c | ~qc[0].v;
        check({phase, "/a_ready"}, 32'(ir_a), 32'(adv_a));
        check({phase, "/b_ready"}, 32'(ir_b), 32'(adv_b));
        check({phase, "/c_ready"}, 32'(ir_c), 32'(adv_c));
        @(posedge clk);
        if (ov_a && or_a) del_a++;
        if (adv_a) begin
            e.v = iv_a; e.y = {3'b000, a_a[s_a]}; e.e = 1'b0;
            void'(qa.pop_front()); qa.push_back(e);
        end
        if (adv_b) begin
            e.v = iv_b;
            e.y = (int'(s_b) < 40) ? a_b[int'(s_b)*4 +: 4] : 4'h0;
            e.e = RCHK & (int'(s_b) >= 40);
            void'(qb.pop_front()); qb.push_back(e);
        end
        if (adv_c) begin
            e.v = iv_c;
            e.y = (int'(s_c) < 5) ? {3'b000, a_c[s_c]} : 4'h0;
            e.e = RCHK & (int'(s_c) >= 5);
            void'(qc.pop_front()); qc.push_back(e);
        end
        @(negedge clk);
        check({phase, "/a_valid"}, 32'(ov_a), 32'(qa[0].v));
        check({phase, "/b_valid"}, 32'(ov_b), 32'(qb[0].v));
        check({phase, "/c_valid"}, 32'(ov_c), 32'(qc[0].v));
        if (qa[0].v) check({phase, "/a_y"}, 32'(y_a), 32'(qa[0].y));
        if (qb[0].v) check({phase, "/b_y"}, 32'(y_b), 32'(qb[0].y));
        if (qc[0].v) check({phase, "/c_y"}, 32'(y_c), 32'(qc[0].y));
        check({phase, "/a_err"}, 32'(err_a), 32'(qa[0].v & qa[0].e));
        check({phase, "/b_err"}, 32'(err_b), 32'(qb[0].v & qb[0].e));
        check({phase, "/c_err"}, 32'(err_c), 32'(qc[0].v & qc[0].e));
    endtask

    initial begin
        idle_inputs();
        reset_models();
        repeat (3) @(negedge clk);
        check("reset/a_valid", 32'(ov_a), 32'd0);
        check("reset/a_y", 32'(y_a), 32'd0);
        check("reset/b_y", 32'(y_b), 32'd0);
        check("reset/a_ready", 32'(ir_a), 32'd1);
        check("reset/b_err", 32'(err_b), 32'd0);
        check("reset/c_valid", 32'(ov_c), 32'd0);
        rst_n = 1'b1;

        phase = "walk";
        for (int i = 0; i < 64; i++) begin
            a_a = 64'd1 << i; s_a = 6'(i); iv_a = 1'b1;
            cycle();
        end
        iv_a = 1'b0;
        repeat (3) cycle();

        phase = "inverse";
        for (int i = 0; i < 64; i++) begin
            a_a = ~(64'd1 << i); s_a = 6'(i); iv_a = 1'b1;
            cycle();
        end
        for (int i = 0; i < 63; i++) begin
            a_a = ~(64'd1 << i); s_a = 6'(i + 1);
            cycle();
        end
        iv_a = 1'b0;
        repeat (3) cycle();

        phase = "backpressure";
        del_a = 0;
        a_a = 64'd1 << 36; s_a = 6'd36; iv_a = 1'b1; cycle();
        a_a = 64'd1 << 38; s_a = 6'd38; cycle();
        a_a = 64'd1 << 60; s_a = 6'd60; or_a = 1'b0;
        repeat (3) cycle();
        or_a = 1'b1; cycle();
        iv_a = 1'b0;
        repeat (4) cycle();
        check("backpressure/delivered", 32'(del_a), 32'd3);

        phase = "midreset";
        a_a = 64'd1 << 5; s_a = 6'd5; iv_a = 1'b1; cycle();
        a_a = 64'd1 << 6; s_a = 6'd6; cycle();
        iv_a = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset/a_valid", 32'(ov_a), 32'd0);
        check("midreset/a_y", 32'(y_a), 32'd0);
        check("midreset/a_ready", 32'(ir_a), 32'd1);
        reset_models();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle();

        phase = "range";
        a_b = '1; iv_b = 1'b1;
        s_b = 6'd45; cycle();
        s_b = 6'd39; cycle();
        s_b = 6'd40; cycle();
        s_b = 6'd63; cycle();
        s_b = 6'd0;  cycle();
        iv_b = 1'b0;
        repeat (3) cycle();

        phase = "odd";
        a_c = 5'b10000; iv_c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_c = 3'(i); cycle();
        end
        iv_c = 1'b0;
        repeat (4) cycle();

        phase = "random";
        for (int n = 0; n < 400; n++) begin
            a_a = {$urandom, $urandom}; s_a = 6'($urandom_range(0, 63));
            iv_a = 1'($urandom_range(0, 1)); or_a = ($urandom_range(0, 3) != 0);
            a_b = {$urandom, $urandom, $urandom, $urandom, $urandom};
            s_b = 6'($urandom_range(0, 63));
            iv_b = 1'($urandom_range(0, 1)); or_b = ($urandom_range(0, 3) != 0);
            a_c = 5'($urandom); s_c = 3'($urandom_range(0, 7));
            iv_c = 1'($urandom_range(0, 1)); or_c = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_inputs();
        repeat (5) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
